mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8'd255; max cycles waited for if_ack/mem_ack before error.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  output  1  instruction fetch request.
REQ-005 if_ack  input  1  fetch data valid; IR loads this cycle.
REQ-006 dec_branch, dec_jump, dec_jalr, dec_mem_ren, dec_mem_wen, dec_reg_wen, dec_ebreak  input  1 each  decoder outputs, stable from DECODE through WB.
REQ-007 br_taken  input  1  branch condition from ALU flags.
REQ-008 mem_req  output  1  data memory request.
REQ-009 mem_we  output  1  data memory write enable.
REQ-010 mem_ack  input  1  data memory completion.
REQ-011 ir_wen  output  1  instruction register load strobe.
REQ-012 rf_wen  output  1  register file write strobe.
REQ-013 pc_wen  output  1  PC update strobe.
REQ-014 pc_sel  output  2  00 pc+4, 01 pc+imme, 10 jalr target.
REQ-015 retire  output  1  one-cycle instruction-complete pulse.
REQ-016 halt  output  1  ebreak reached, sticky.
REQ-017 err  output  1  handshake timeout, sticky.
REQ-018 state  output  3  current FSM state.
REQ-019 instret  output  32  retired instruction count.

Function
REQ-020 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; code 7 SHALL go to ERR.
REQ-021 FETCH: if_req=1; on if_ack ir_wen=1 same cycle, next DECODE; otherwise stay.
REQ-022 DECODE: dec_ebreak -> HALT; else -> EXEC.
REQ-023 EXEC: dec_mem_ren|dec_mem_wen -> MEM; else -> WB; no strobes asserted.
REQ-024 MEM: mem_req=1, mem_we=dec_mem_wen; on mem_ack -> WB; otherwise stay.
REQ-025 WB: pc_wen=1, retire=1, rf_wen=dec_reg_wen & ~dec_mem_wen & ~dec_branch; next FETCH.
REQ-026 pc_sel in WB: dec_jalr -> 10; dec_jump&~dec_jalr -> 01; dec_branch&br_taken -> 01; else 00; pc_sel=00 outside WB.
REQ-027 All strobes (if_req, ir_wen, mem_req, mem_we, rf_wen, pc_wen, retire) SHALL be 0 in any state not listed for them.
REQ-028 Wait counter, 8 bits: clears on entry to FETCH or MEM and on any ack; increments each waiting cycle in FETCH/MEM without ack.
REQ-029 Counter reaching TIMEOUT without ack SHALL move FSM to ERR next cycle; ack in the same cycle wins.
REQ-030 HALT: halt=1, all strobes 0, exits only via rst.
REQ-031 ERR: err=1, all strobes 0, exits only via rst.
REQ-032 instret increments by 1 on each retire cycle; wraps 32'hFFFFFFFF -> 0.
REQ-033 Latency: non-memory instruction = 4 cycles after if_ack cycle inclusive (FETCH,DECODE,EXEC,WB) with zero-wait ack; load/store = 5.
REQ-034 ebreak SHALL not retire and SHALL not update PC.

Reset
REQ-035 rst=1 SHALL asynchronously force state=FETCH, wait counter=0, instret=0, halt=0, err=0.
REQ-036 During rst all outputs SHALL be 0, including if_req; if_req rises on first clock edge after rst release only as a function of state FETCH.
REQ-037 rst asserted mid-MEM SHALL drop mem_req and mem_we immediately, without waiting for an edge.

Verification
REQ-038 ADD with if_ack held 1 -> states 0,1,2,4,0; rf_wen=1, pc_sel=00, retire=1 in WB; instret=1.
REQ-039 LW, mem_ack after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, rf_wen=1 in WB.
REQ-040 BEQ with br_taken=1 then br_taken=0 -> pc_sel=01 then 00, rf_wen=0 both times.
REQ-041 SW with mem_ack never asserted, TIMEOUT=4 -> ERR after 4 waiting cycles, err=1, mem_req=0.
REQ-042 Instruction 32'h00100073 (dec_ebreak=1) -> HALT from DECODE, halt=1, instret unchanged, pc_wen never 1.
REQ-043 rst pulse mid-MEM, then release -> mem_req=0 asynchronously, state=0, instret=0, if_req=1 after first edge.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// ============================================================================
// mcycle_ctrl : multi-cycle CPU control FSM (fetch/decode/exec/mem/wb)
// rev 1.0
// ============================================================================
`default_nettype none

module mcycle_ctrl #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_if_req,
   input  logic        i_if_ack,
   input  logic        i_dec_branch,
   input  logic        i_dec_jump,
   input  logic        i_dec_jalr,
   input  logic        i_dec_mem_ren,
   input  logic        i_dec_mem_wen,
   input  logic        i_dec_reg_wen,
   input  logic        i_dec_ebreak,
   input  logic        i_br_taken,
   output logic        o_mem_req,
   output logic        o_mem_we,
   input  logic        i_mem_ack,
   output logic        o_ir_wen,
   output logic        o_rf_wen,
   output logic        o_pc_wen,
   output logic [1:0]  o_pc_sel,
   output logic        o_retire,
   output logic        o_halt,
   output logic        o_err,
   output logic [2:0]  o_state,
   output logic [31:0] o_instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_run;
   logic [7:0]  r_wait_cnt;
   logic [31:0] r_instret;

   logic [7:0]  w_wait_inc;
   logic        w_tmo;
   logic        w_waiting;
   logic        w_if_req;
   logic        w_ir_wen;
   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_rf_wen;
   logic        w_pc_wen;
   logic [1:0]  w_pc_sel;
   logic        w_retire;

   assign w_wait_inc = r_wait_cnt + 8'd1;
   assign w_tmo      = (w_wait_inc == TIMEOUT);

   // r_run is cleared asynchronously by rst and set on the first edge after
   // release, so every strobe is held low during reset and up to that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_waiting    = 1'b0;
      w_if_req     = 1'b0;
      w_ir_wen     = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_rf_wen     = 1'b0;
      w_pc_wen     = 1'b0;
      w_pc_sel     = 2'b00;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (r_run) begin
               w_if_req = 1'b1;
               if (i_if_ack) begin
                  w_ir_wen     = 1'b1;
                  w_state_next = S_DECODE;
               end else begin
                  w_waiting = 1'b1;
                  if (w_tmo) w_state_next = S_ERR;
               end
            end
         end
         S_DECODE: w_state_next = i_dec_ebreak ? S_HALT : S_EXEC;
         S_EXEC:   w_state_next = (i_dec_mem_ren | i_dec_mem_wen) ? S_MEM : S_WB;
         S_MEM: begin
            w_mem_req = r_run;
            w_mem_we  = r_run & i_dec_mem_wen;
            if (i_mem_ack) begin
               w_state_next = S_WB;
            end else begin
               w_waiting = 1'b1;
               if (w_tmo) w_state_next = S_ERR;
            end
         end
         S_WB: begin
            w_pc_wen     = 1'b1;
            w_retire     = 1'b1;
            w_rf_wen     = i_dec_reg_wen & ~i_dec_mem_wen & ~i_dec_branch;
            w_state_next = S_FETCH;
            if (i_dec_jalr)
               w_pc_sel = 2'b10;
            else if (i_dec_jump || (i_dec_branch && i_br_taken))
               w_pc_sel = 2'b01;
         end
         S_HALT:  w_state_next = S_HALT;
         S_ERR:   w_state_next = S_ERR;
         default: w_state_next = S_ERR;
      endcase
   end

   // Any state change (ack, timeout, normal advance) restarts the wait count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wait_cnt <= 8'd0;
      else if (w_state_next != r_state)
         r_wait_cnt <= 8'd0;
      else if (w_waiting)
         r_wait_cnt <= w_wait_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_instret <= 32'd0;
      else if (w_retire)
         r_instret <= r_instret + 32'd1;
   end

   assign o_if_req  = w_if_req;
   assign o_ir_wen  = w_ir_wen;
   assign o_mem_req = w_mem_req;
   assign o_mem_we  = w_mem_we;
   assign o_rf_wen  = w_rf_wen;
   assign o_pc_wen  = w_pc_wen;
   assign o_pc_sel  = w_pc_sel;
   assign o_retire  = w_retire;
   assign o_halt    = (r_state == S_HALT);
   assign o_err     = (r_state == S_ERR);
   assign o_state   = r_state;
   assign o_instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================================
// tb_mcycle_ctrl : scoreboard bench for mcycle_ctrl (TIMEOUT = 4)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_mcycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        o_if_req, i_if_ack = 1'b0;
   logic        i_dec_branch = 1'b0, i_dec_jump = 1'b0, i_dec_jalr = 1'b0;
   logic        i_dec_mem_ren = 1'b0, i_dec_mem_wen = 1'b0;
   logic        i_dec_reg_wen = 1'b0, i_dec_ebreak = 1'b0;
   logic        i_br_taken = 1'b0;
   logic        o_mem_req, o_mem_we, i_mem_ack = 1'b0;
   logic        o_ir_wen, o_rf_wen, o_pc_wen, o_retire, o_halt, o_err;
   logic [1:0]  o_pc_sel;
   logic [2:0]  o_state;
   logic [31:0] o_instret;

   // decoder vector {ebreak, reg_wen, mem_wen, mem_ren, jalr, jump, branch}
   localparam logic [6:0] c_ADD  = 7'b0100000;
   localparam logic [6:0] c_LW   = 7'b0101000;
   localparam logic [6:0] c_SW   = 7'b0110000;
   localparam logic [6:0] c_BEQ  = 7'b0000001;
   localparam logic [6:0] c_JAL  = 7'b0100010;
   localparam logic [6:0] c_JALR = 7'b0100110;
   localparam logic [6:0] c_EBRK = 7'b1000000;

   typedef struct {
      logic [1:0]  pc_sel;
      logic        rf_wen;
      logic [31:0] instret;
   } sb_t;

   sb_t         sb_q[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_instret = 32'd0;

   mcycle_ctrl #(.TIMEOUT(8'd4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .o_if_req     (o_if_req),
      .i_if_ack     (i_if_ack),
      .i_dec_branch (i_dec_branch),
      .i_dec_jump   (i_dec_jump),
      .i_dec_jalr   (i_dec_jalr),
      .i_dec_mem_ren(i_dec_mem_ren),
      .i_dec_mem_wen(i_dec_mem_wen),
      .i_dec_reg_wen(i_dec_reg_wen),
      .i_dec_ebreak (i_dec_ebreak),
      .i_br_taken   (i_br_taken),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .i_mem_ack    (i_mem_ack),
      .o_ir_wen     (o_ir_wen),
      .o_rf_wen     (o_rf_wen),
      .o_pc_wen     (o_pc_wen),
      .o_pc_sel     (o_pc_sel),
      .o_retire     (o_retire),
      .o_halt       (o_halt),
      .o_err        (o_err),
      .o_state      (o_state),
      .o_instret    (o_instret)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every retire pulse must match the oldest queued entry.
   always @(negedge clk) begin : sb_mon
      sb_t e;
      if (!rst && o_retire === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("retire_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_val("wb_pc_sel",  {30'd0, o_pc_sel}, {30'd0, e.pc_sel});
            check_val("wb_rf_wen",  {31'd0, o_rf_wen}, {31'd0, e.rf_wen});
            check_val("wb_pc_wen",  {31'd0, o_pc_wen}, 32'd1);
            check_val("wb_instret", o_instret, e.instret);
         end
      end
   end

   task automatic check_quiet(input string tag);
      check_val({tag, "_strobes"},
                {25'd0, o_if_req, o_ir_wen, o_mem_req, o_mem_we, o_rf_wen, o_pc_wen, o_retire},
                32'd0);
   endtask

   // Precondition: just after a negedge with the DUT sitting in FETCH.
   task automatic do_instr(input string nm, input logic [6:0] dec, input logic tk, input int mwait);
      logic [1:0] pcs;
      logic       rfw;
      int         nreq;
      sb_t        e;
      {i_dec_ebreak, i_dec_reg_wen, i_dec_mem_wen, i_dec_mem_ren,
       i_dec_jalr, i_dec_jump, i_dec_branch} = dec;
      i_br_taken = tk;
      i_if_ack   = 1'b1;
      i_mem_ack  = 1'b0;
      #1;
      check_val({nm, "_fetch_st"}, {29'd0, o_state}, 32'd0);
      check_val({nm, "_ir_wen"}, {30'd0, o_if_req, o_ir_wen}, 32'd3);
      if (!dec[6]) begin
         if (dec[2])                 pcs = 2'b10;
         else if (dec[1])            pcs = 2'b01;
         else if (dec[0] && tk)      pcs = 2'b01;
         else                        pcs = 2'b00;
         rfw       = dec[5] & ~dec[4] & ~dec[0];
         e.pc_sel  = pcs;
         e.rf_wen  = rfw;
         e.instret = exp_instret;
         sb_q.push_back(e);
      end
      @(negedge clk);
      i_if_ack = 1'b0;
      check_val({nm, "_decode_st"}, {29'd0, o_state}, 32'd1);
      check_quiet({nm, "_decode"});
      if (dec[6]) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val({nm, "_halt_st"}, {29'd0, o_state, o_halt}, 32'd11);
            check_quiet({nm, "_halt"});
            check_val({nm, "_halt_instret"}, o_instret, exp_instret);
         end
         return;
      end
      @(negedge clk);
      check_val({nm, "_exec_st"}, {29'd0, o_state}, 32'd2);
      check_quiet({nm, "_exec"});
      if (dec[4] || dec[3]) begin
         nreq = 0;
         for (int k = 0; k <= mwait; k++) begin
            @(negedge clk);
            check_val({nm, "_mem_st"}, {29'd0, o_state}, 32'd3);
            check_val({nm, "_mem_we"}, {31'd0, o_mem_we}, {31'd0, dec[4]});
            if (o_mem_req === 1'b1) nreq++;
            i_mem_ack = (k == mwait);
         end
         check_val({nm, "_mem_req_cycles"}, nreq, mwait + 1);
      end
      @(negedge clk);
      i_mem_ack = 1'b0;
      check_val({nm, "_wb_st"}, {29'd0, o_state}, 32'd4);
      exp_instret++;
      @(negedge clk);
      check_val({nm, "_next_fetch_st"}, {29'd0, o_state}, 32'd0);
      check_val({nm, "_instret"}, o_instret, exp_instret);
   endtask

   // Asserts rst between edges, checks quiet outputs, releases and ends in FETCH.
   task automatic do_reset(input string nm);
      #2 rst = 1'b1;
      #1;
      check_val({nm, "_rst_state"}, {29'd0, o_state}, 32'd0);
      check_val({nm, "_rst_flags"}, {30'd0, o_halt, o_err}, 32'd0);
      check_val({nm, "_rst_instret"}, o_instret, 32'd0);
      check_quiet({nm, "_rst"});
      sb_q.delete();
      exp_instret = 32'd0;
      i_if_ack  = 1'b0;
      i_mem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val({nm, "_if_req_pre_edge"}, {31'd0, o_if_req}, 32'd0);
      @(negedge clk);
      check_val({nm, "_if_req_post_edge"}, {29'd0, o_state, o_if_req}, 32'd1);
   endtask

   initial begin
      @(negedge clk);
      do_reset("init");

      do_instr("add",    c_ADD,  1'b0, 0);
      do_instr("lw",     c_LW,   1'b0, 3);
      do_instr("sw",     c_SW | 7'b0100000, 1'b0, 0);
      do_instr("beq_t",  c_BEQ | 7'b0100000, 1'b1, 0);
      do_instr("beq_nt", c_BEQ,  1'b0, 0);
      do_instr("jal",    c_JAL,  1'b0, 0);
      do_instr("jalr",   c_JALR, 1'b1, 0);
      check_val("sb_drained_1", sb_q.size(), 0);

      // Store in flight, reset asserted between edges in its second MEM cycle.
      {i_dec_ebreak, i_dec_reg_wen, i_dec_mem_wen, i_dec_mem_ren,
       i_dec_jalr, i_dec_jump, i_dec_branch} = c_SW;
      i_if_ack = 1'b1;
      @(negedge clk); i_if_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_val("midmem_before", {29'd0, o_state, o_mem_req}, 32'd7);
      do_reset("midmem");

      do_instr("add2", c_ADD,  1'b0, 0);
      do_instr("ebrk", c_EBRK, 1'b0, 0);
      do_reset("post_halt");

      // Store whose ack never comes: 4 waiting MEM cycles, then ERR.
      {i_dec_ebreak, i_dec_reg_wen, i_dec_mem_wen, i_dec_mem_ren,
       i_dec_jalr, i_dec_jump, i_dec_branch} = c_SW;
      i_if_ack = 1'b1;
      @(negedge clk); i_if_ack = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("sw_tmo_mem", {29'd0, o_state, o_mem_req}, 32'd7);
      end
      @(negedge clk);
      check_val("sw_tmo_err", {29'd0, o_state, o_err}, 32'd13);
      check_quiet("sw_tmo_err");
      i_if_ack  = 1'b1;
      i_mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      check_val("err_sticky", {29'd0, o_state, o_err}, 32'd13);
      check_quiet("err_sticky");
      do_reset("post_err");

      // Fetch with no ack: if_req waits 4 cycles from the first counted edge.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("if_tmo_wait", {29'd0, o_state, o_if_req}, 32'd1);
      end
      @(negedge clk);
      check_val("if_tmo_err", {29'd0, o_state, o_err}, 32'd13);
      check_val("sb_drained_2", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule

`default_nettype wire
